fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 8 and set the data word width.
REQ-002 The parameter ADDR_WIDTH SHALL default to 4 and set the RAM address width; pointers SHALL be ADDR_WIDTH+1 bits wide.
REQ-003 The port g_clk SHALL be a 1-bit input and the read-domain clock.
REQ-004 The port w_rst SHALL be a 1-bit input reset, asynchronous, active-low.
REQ-005 The port wptr_gray SHALL be an ADDR_WIDTH+1-bit input carrying the write pointer in Gray code from the write domain.
REQ-006 The port rptr_gray SHALL be an ADDR_WIDTH+1-bit output carrying the registered read pointer in Gray code, sent to the write domain.
REQ-007 The port raddr SHALL be an ADDR_WIDTH-bit output giving the RAM read address, equal to rbin[ADDR_WIDTH-1:0].
REQ-008 The port rdata SHALL be a DATA_WIDTH-bit input carrying RAM read data, valid one g_clk cycle after raddr.
REQ-009 The port dout SHALL be a DATA_WIDTH-bit output carrying the registered output word.
REQ-010 The port dout_valid SHALL be a 1-bit output; high means dout holds an unconsumed word.
REQ-011 The port dout_ready SHALL be a 1-bit input; the consumer accepts dout when dout_valid and dout_ready are both high at a rising edge.
REQ-012 The port rempty SHALL be a 1-bit output; high means no unread word remains in the RAM.

Function
REQ-013 wptr_gray SHALL pass through a 2-flop synchronizer clocked by g_clk, producing wq2; no other logic SHALL sample wptr_gray.
REQ-014 rempty SHALL be a register loaded with (gray(rbin_next) == wq2) each cycle.
REQ-015 The FSM SHALL have three states: EMPTY, FETCH and VALID.
REQ-016 In EMPTY with rempty=0, the block SHALL increment rbin (rinc) and go to FETCH; otherwise it SHALL stay in EMPTY.
REQ-017 In FETCH, dout SHALL load rdata and the FSM SHALL go to VALID, so dout_valid rises 2 cycles after rempty falls.
REQ-018 In VALID with no accept, dout and dout_valid SHALL hold.
REQ-019 In VALID with accept and rempty=0, the block SHALL rinc and go to FETCH, giving a one-cycle dout_valid bubble.
REQ-020 In VALID with accept and rempty=1, the FSM SHALL go to EMPTY.
REQ-021 rinc SHALL never occur while rempty=1, so there is no underflow.
REQ-022 rbin SHALL wrap from 2^(ADDR_WIDTH+1)-1 to 0, and the MSB toggle SHALL distinguish full from empty laps.
REQ-023 rptr_gray SHALL be registered from gray(rbin_next) on every edge, with at most one bit changing per increment.

Reset
REQ-024 On w_rst low, the block SHALL clear rbin, rptr_gray, both synchronizer stages, dout and dout_valid to 0, set rempty to 1 and set the FSM to EMPTY, regardless of the state it was in.
REQ-025 After w_rst rises, the first rinc SHALL occur no earlier than 3 cycles later (2 synchronizer cycles plus the rempty register).

Configuration
REQ-026 With RD_LEVEL_EN defined, the block SHALL provide an ADDR_WIDTH+1-bit output rlevel, registered as gray2bin(wq2) - rbin modulo 2^(ADDR_WIDTH+1), with reset value 0.
REQ-027 Without RD_LEVEL_EN, the rlevel port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The shared package fifo_pkg SHALL hold the default widths and the bin2gray and gray2bin functions, shared with the write-side controller.
REQ-029 The synchronizer SHALL be a sub-module ptr_sync (parameter WIDTH, 2 flops, async active-low reset), reused by the write side.

Verification
REQ-030 Bench scenario: reset, then hold wptr_gray=0 for 10 cycles -> rempty=1, dout_valid=0 and raddr=0 throughout.
REQ-031 Bench scenario: the RAM model holds 0xA5 at address 0, then wptr_gray steps to 00001 -> rempty falls 3 cycles later, dout_valid=1 with dout=0xA5 2 cycles after that, and rptr_gray=00001.
REQ-032 Bench scenario: 4 words are written and dout_ready is held at 1 -> the 4 words appear in order, one every 2 cycles, and the FSM returns to EMPTY with rempty=1.
REQ-033 Bench scenario: dout_ready=0 while dout_valid=1 for 5 cycles -> dout is stable and rbin does not advance.
REQ-034 Bench scenario: 40 words are streamed through -> raddr wraps 15 to 0, rbin wraps 31 to 0, and every rptr_gray step changes exactly 1 bit.
REQ-035 Bench scenario: w_rst is asserted in FETCH -> outputs reach their reset values immediately, and with RD_LEVEL_EN defined, rlevel=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write controllers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fifo_pkg;

  // Default geometry shared by both FIFO controllers.
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Pointer helpers work on a 32-bit container; callers cast to their
  // own pointer width, so pointers up to 32 bits are supported.
  localparam int FIFO_PTR_MAX_W = 32;

  // Read-side controller states.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_e;

  // Binary to reflected Gray code.
  function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(
    input logic [FIFO_PTR_MAX_W-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(
    input logic [FIFO_PTR_MAX_W-1:0] gray
  );
    logic [FIFO_PTR_MAX_W-1:0] bin;
    bin[FIFO_PTR_MAX_W-1] = gray[FIFO_PTR_MAX_W-1];
    for (int i = FIFO_PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Latency: 2 g_clk cycles from sync_in to sync_out.
// Backpressure: none; samples every cycle.
module ptr_sync #(
  parameter int WIDTH = 5
) (
  input  logic             g_clk,
  input  logic             w_rst,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // First stage captures the foreign-domain pointer, second stage settles it.
  always_comb begin
    meta_d = sync_in;
    sync_d = meta_q;
  end

  // Both stages clear asynchronously so the pointer reads as zero in reset.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: RAM read pointer, empty flag, registered output word.
// Latency: dout_valid rises 2 g_clk after rempty falls; 1 idle cycle between back-to-back words.
// Backpressure: dout/dout_valid hold until dout_ready; optional rlevel output with RD_LEVEL_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  g_clk,
  input  logic                  w_rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  rempty
`ifdef RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   rlevel
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // Write pointer as seen in the read domain.
  logic [PW-1:0] wq2;

  rd_state_e             state_d, state_q;
  logic [PW-1:0]         rbin_d, rbin_q;
  logic [PW-1:0]         rptr_gray_d, rptr_gray_q;
  logic                  rempty_d, rempty_q;
  logic [DATA_WIDTH-1:0] dout_d, dout_q;
  logic                  dout_valid_d, dout_valid_q;
  logic                  accept;
  logic                  rinc;

  // The only consumer of wptr_gray: bring it into g_clk before any use.
  ptr_sync #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .g_clk    (g_clk),
    .w_rst    (w_rst),
    .sync_in  (wptr_gray),
    .sync_out (wq2)
  );

  // Next-state, pointer advance and empty detection.
  always_comb begin
    accept       = dout_valid_q & dout_ready;
    rinc         = 1'b0;
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    case (state_q)
      EMPTY: begin
        // rempty is registered, so a word is only fetched once the
        // synchronized write pointer has shown it is really there.
        if (!rempty_q) begin
          rinc    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // RAM data for the address issued last cycle is now on rdata.
        dout_d       = rdata;
        dout_valid_d = 1'b1;
        state_d      = VALID;
      end
      VALID: begin
        if (accept) begin
          dout_valid_d = 1'b0;
          if (!rempty_q) begin
            rinc    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        dout_valid_d = 1'b0;
        state_d      = EMPTY;
      end
    endcase

    // rinc is only raised with rempty_q low, so the pointer cannot overrun.
    // The extra MSB wraps naturally and marks the lap for full/empty.
    rbin_d      = rbin_q + {{ADDR_WIDTH{1'b0}}, rinc};
    rptr_gray_d = PW'(bin2gray(FIFO_PTR_MAX_W'(rbin_d)));
    rempty_d    = (rptr_gray_d == wq2);
  end

  // Controller state and all registered outputs update together.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q      <= EMPTY;
      rbin_q       <= '0;
      rptr_gray_q  <= '0;
      rempty_q     <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rbin_q       <= rbin_d;
      rptr_gray_q  <= rptr_gray_d;
      rempty_q     <= rempty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign rptr_gray  = rptr_gray_q;
  assign raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign rempty     = rempty_q;

`ifdef RD_LEVEL_EN
  logic [PW-1:0] rlevel_d, rlevel_q;

  // Occupancy from the read side's view; lags writes by the sync delay.
  always_comb begin
    rlevel_d = PW'(gray2bin(FIFO_PTR_MAX_W'(wq2))) - rbin_q;
  end

  // Registered so the level is a clean flop output.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= rlevel_d;
    end
  end

  assign rlevel = rlevel_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a same-clock write-side and RAM model.
// Latency: checks sampled 1 time unit after each rising g_clk.
// Backpressure: drives dout_ready directly; the writer never overfills the RAM.
module tb_fifo_read_ctrl;

  logic       g_clk;
  logic       w_rst;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_gray;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       rempty;
`ifdef RD_LEVEL_EN
  logic [4:0] rlevel;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [16];
  logic [4:0] wbin;

  fifo_read_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .g_clk      (g_clk),
    .w_rst      (w_rst),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .raddr      (raddr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rempty     (rempty)
`ifdef RD_LEVEL_EN
    ,
    .rlevel     (rlevel)
`endif
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Synchronous-read RAM: data for raddr appears one cycle later.
  always @(posedge g_clk) rdata <= mem[raddr];

  function automatic logic [4:0] tb_b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] tb_g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] val);
    mem[wbin[3:0]] = val;
    wbin      = wbin + 5'd1;
    wptr_gray = tb_b2g(wbin);
  endtask

  // Stream n words with dout_ready high; one write per cycle while room remains.
  task automatic stream(input int n, input bit chk_gap,
                        output bit saw_addr_wrap, output bit saw_bin_wrap);
    logic [7:0] exp_q[$];
    int         wr = 0;
    int         rd = 0;
    int         cyc = 0;
    int         last = -1;
    logic [4:0] prev_g;
    logic [3:0] prev_a;
    logic [4:0] lvl;
    logic [7:0] w;
    prev_g = rptr_gray;
    prev_a = raddr;
    saw_addr_wrap = 1'b0;
    saw_bin_wrap  = 1'b0;
    while (rd < n && cyc < 2000) begin
      lvl = wbin - tb_g2b(rptr_gray);
      if (wr < n && lvl < 5'd15) begin
        w = 8'((wr * 7) + 17 + n);
        push_word(w);
        exp_q.push_back(w);
        wr++;
      end
      tick();
      cyc++;
      if (dout_valid) begin
        if (exp_q.size() == 0) check_val("extra_word", 1, 0);
        else check_val("stream_dout", dout, exp_q.pop_front());
        if (chk_gap && last >= 0) check_val("stream_gap", cyc - last, 2);
        last = cyc;
        rd++;
      end
      if (rptr_gray != prev_g) begin
        check_val("gray_one_bit", $countones(rptr_gray ^ prev_g), 1);
        if (tb_g2b(prev_g) == 5'd31 && tb_g2b(rptr_gray) == 5'd0) saw_bin_wrap = 1'b1;
        prev_g = rptr_gray;
      end
      if (prev_a == 4'd15 && raddr == 4'd0) saw_addr_wrap = 1'b1;
      prev_a = raddr;
    end
    if (rd < n) check_val("stream_timeout", rd, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit aw, bw;
    int waited;
    logic [4:0] g0;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    w_rst      = 1'b0;
    wbin       = 5'd0;
    wptr_gray  = 5'd0;
    dout_ready = 1'b0;
    tick();
    tick();

    // Reset values
    check_val("rst_rempty", rempty, 1);
    check_val("rst_dout_valid", dout_valid, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_rptr_gray", rptr_gray, 0);
    check_val("rst_raddr", raddr, 0);
`ifdef RD_LEVEL_EN
    check_val("rst_rlevel", rlevel, 0);
`endif

    w_rst = 1'b1;

    // Idle with nothing written
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_rempty", rempty, 1);
      check_val("idle_dout_valid", dout_valid, 0);
      check_val("idle_raddr", raddr, 0);
    end

    // First word: empty drops after 3 edges, data 2 edges later
    push_word(8'hA5);
    tick();
    tick();
    check_val("w1_rempty_2cyc", rempty, 1);
    tick();
    check_val("w1_rempty_3cyc", rempty, 0);
    tick();
    check_val("w1_fetch_valid", dout_valid, 0);
    check_val("w1_rptr_gray", rptr_gray, 5'b00001);
    tick();
    check_val("w1_dout_valid", dout_valid, 1);
    check_val("w1_dout", dout, 8'hA5);
    check_val("w1_rempty_again", rempty, 1);

    // Hold off the consumer while a second word is available
    push_word(8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("hold_dout", dout, 8'hA5);
      check_val("hold_dout_valid", dout_valid, 1);
      check_val("hold_rptr_gray", rptr_gray, 5'b00001);
      check_val("hold_raddr", raddr, 1);
    end
    check_val("hold_rempty", rempty, 0);
`ifdef RD_LEVEL_EN
    check_val("hold_rlevel", rlevel, 1);
`endif

    dout_ready = 1'b1;
    tick();
    check_val("w2_bubble", dout_valid, 0);
    check_val("w2_rptr_gray", rptr_gray, tb_b2g(5'd2));
    tick();
    check_val("w2_dout_valid", dout_valid, 1);
    check_val("w2_dout", dout, 8'h3C);
    tick();
    check_val("w2_drained", dout_valid, 0);
    check_val("w2_rempty", rempty, 1);

    // Four words back to back, one every 2 cycles
    stream(4, 1'b1, aw, bw);
    tick();
    check_val("four_end_valid", dout_valid, 0);
    check_val("four_end_rempty", rempty, 1);
    check_val("four_end_rptr", rptr_gray, tb_b2g(5'd6));
    tick();
    check_val("four_idle_valid", dout_valid, 0);

    // Forty words across both pointer wraps
    stream(40, 1'b0, aw, bw);
    check_val("wrap_raddr", aw, 1);
    check_val("wrap_rbin", bw, 1);
    tick();
    check_val("forty_end_rempty", rempty, 1);
    check_val("forty_end_rptr", rptr_gray, tb_b2g(5'd14));

    // Reset asserted in FETCH
    g0 = rptr_gray;
    push_word(8'h77);
    waited = 0;
    while (rptr_gray == g0 && waited < 20) begin
      tick();
      waited++;
    end
    if (rptr_gray == g0) check_val("fetch_timeout", waited, 0);
    check_val("pre_rst_in_fetch", dout_valid, 0);
    w_rst = 1'b0;
    #1;
    check_val("arst_rptr_gray", rptr_gray, 0);
    check_val("arst_raddr", raddr, 0);
    check_val("arst_dout", dout, 0);
    check_val("arst_dout_valid", dout_valid, 0);
    check_val("arst_rempty", rempty, 1);
`ifdef RD_LEVEL_EN
    check_val("arst_rlevel", rlevel, 0);
`endif
    wbin      = 5'd0;
    wptr_gray = 5'd0;
    dout_ready = 1'b0;
    tick();
    tick();
    w_rst = 1'b1;

    // No read increment within 3 cycles of reset release
    push_word(8'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_rst_no_rinc", rptr_gray, 0);
    end
    tick();
    check_val("post_rst_rinc", rptr_gray, 5'b00001);
    tick();
    check_val("post_rst_dout_valid", dout_valid, 1);
    check_val("post_rst_dout", dout, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
